// File: rtl/memory_dump_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : memory_dump_tx                                             |
// | Description : Serial transmitter for memory contents. On an accepted     |
// |               start it reads words first_addr..last_addr (inclusive)     |
// |               through a read-only memory port and sends each word as a   |
// |               UART-style frame: start bit, DATA_WIDTH data bits LSB      |
// |               first, stop bit. Used after boot to dump instruction or    |
// |               data memory for debug and load verification.               |
// | Ports       : clock        system clock, all logic on posedge            |
// |               reset        synchronous active-high reset                 |
// |               start        dump request, sampled only in IDLE            |
// |               first_addr   first word address, latched on accept         |
// |               last_addr    last word address (inclusive), latched        |
// |               mem_data     combinational read data for mem_address       |
// |               mem_address  memory read address                           |
// |               mem_oe       memory output enable, active-high             |
// |               tx           serial output, idle high                      |
// |               busy         high while a dump is in progress              |
// |               done         one-cycle pulse on completion or rejection    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module memory_dump_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] first_addr,
   input  logic [ADDR_WIDTH-1:0] last_addr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_oe,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int c_BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_LATCH = 3'd2,
      S_START = 3'd3,
      S_DATA  = 3'd4,
      S_STOP  = 3'd5,
      S_NEXT  = 3'd6
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] r_last;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [c_BAUD_W-1:0]   r_baud;
   logic [c_BIT_W-1:0]    r_bit;
   logic                  r_oe;
   logic                  r_tx;
   logic                  r_busy;
   logic                  r_done;

   logic [DATA_WIDTH-1:0] w_shift_next;
   logic                  w_baud_end;

   assign w_shift_next = r_shift >> 1;
   assign w_baud_end   = (r_baud == c_BAUD_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_last  <= '0;
         r_shift <= '0;
         r_baud  <= '0;
         r_bit   <= '0;
         r_oe    <= 1'b0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // A start coinciding with the done pulse is dropped so the
               // requester always sees done before a new dump can begin.
               if (start && !r_done) begin
                  r_last <= last_addr;
                  if (last_addr < first_addr) begin
                     r_done <= 1'b1;
                  end else begin
                     r_addr  <= first_addr;
                     r_oe    <= 1'b1;
                     r_busy  <= 1'b1;
                     r_state <= S_READ;
                  end
               end
            end
            S_READ: begin
               r_state <= S_LATCH;
            end
            S_LATCH: begin
               r_shift <= mem_data;
               r_oe    <= 1'b0;
               r_tx    <= 1'b0;
               r_baud  <= '0;
               r_state <= S_START;
            end
            S_START: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_DATA: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_bit == c_BIT_LAST) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_bit   <= r_bit + 1'b1;
                     r_shift <= w_shift_next;
                     r_tx    <= w_shift_next[0];
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_STOP: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_state <= S_NEXT;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_NEXT: begin
               // Compare before increment so an all-ones last address
               // terminates instead of wrapping to zero.
               if (r_addr == r_last) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_addr  <= r_addr + 1'b1;
                  r_oe    <= 1'b1;
                  r_state <= S_READ;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_address = r_addr;
   assign mem_oe      = r_oe;
   assign tx          = r_tx;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_memory_dump_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_memory_dump_tx                                          |
// | Description : Self-checking bench for memory_dump_tx. Dumps are issued   |
// |               with expected reads, frames and done pulses queued from a  |
// |               word-level model; independent monitors decode the serial   |
// |               line, the memory port and done, and compare against them.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_memory_dump_tx;

   localparam int CPB = 4;
   localparam int DW  = 32;
   localparam int AW  = 32;

   logic          clock;
   logic          reset;
   logic          start;
   logic [AW-1:0] first_addr;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] mem_data;
   logic [AW-1:0] mem_address;
   logic          mem_oe;
   logic          tx;
   logic          busy;
   logic          done;

   memory_dump_tx #(
      .CLKS_PER_BIT (CPB),
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .first_addr  (first_addr),
      .last_addr   (last_addr),
      .mem_data    (mem_data),
      .mem_address (mem_address),
      .mem_oe      (mem_oe),
      .tx          (tx),
      .busy        (busy),
      .done        (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Memory contents: either a small table (directed tests) or a hash of the address.
   logic [31:0] tbl [16];
   bit          use_tbl;
   logic [31:0] seed;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (use_tbl) return tbl[a[3:0]];
      return (a * 32'h9E3779B1) ^ seed;
   endfunction

   always_comb begin
      mem_data = 32'h0;
      if (mem_oe) mem_data = mem_word(mem_address);
   end

   typedef struct {
      logic [31:0] word;
      bit          first;
      int          acc;
   } frame_t;

   frame_t      frame_q [$];
   logic [31:0] addr_q  [$];
   int          done_q  [$];   // -1: after last frame; otherwise absolute cycle

   int checks   = 0;
   int failures = 0;
   int last_stop = 0;
   bit watch_zero = 0;
   bit saw_zero   = 0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- serial receiver / frame scoreboard ----------------
   task automatic rx_frame();
      int              fall;
      logic [DW+1:0]   fr;
      bit              stable;
      bit              abort;
      logic            bv;
      frame_t          e;
      fall   = cyc;
      fr     = '0;
      stable = 1'b1;
      abort  = 1'b0;
      bv     = 1'b0;
      for (int b = 0; b < DW + 2 && !abort; b++) begin
         for (int c = 0; c < CPB && !abort; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clock);
            if (reset) abort = 1'b1;
            else begin
               if (c == 0) bv = tx;
               else if (tx !== bv) stable = 1'b0;
               fr[b] = bv;
            end
         end
      end
      if (!abort) begin
         if (frame_q.size() == 0) begin
            chk(1'b0, "unexpected_frame", fr[DW:1], 0);
         end else begin
            e = frame_q.pop_front();
            chk(fr[0] == 1'b0 && fr[DW+1] == 1'b1 && stable, "frame_format",
                {fr[DW+1], fr[0], stable}, 3'b101);
            chk(fr[DW:1] == e.word, "frame_data", fr[DW:1], e.word);
            if (e.first) chk(fall == e.acc + 3, "start_latency", fall - e.acc, 3);
            else         chk(fall == last_stop + 4, "frame_gap", fall - last_stop - 1, 3);
         end
         last_stop = cyc;
      end
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (!reset && tx === 1'b0) rx_frame();
      end
   end

   // ---------------- memory port monitor ----------------
   initial begin
      bit          oe_prev;
      int          oe_w;
      logic [31:0] oe_addr;
      logic [31:0] ea;
      oe_prev = 1'b0;
      oe_w    = 0;
      oe_addr = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            oe_prev = 1'b0;
            oe_w    = 0;
         end else begin
            if (mem_oe === 1'b1) begin
               if (!oe_prev) begin
                  oe_w    = 1;
                  oe_addr = mem_address;
                  if (addr_q.size() == 0) chk(1'b0, "unexpected_read", mem_address, 0);
                  else begin
                     ea = addr_q.pop_front();
                     chk(mem_address == ea, "read_addr", mem_address, ea);
                  end
                  chk(busy == 1'b1, "busy_in_read", busy, 1);
               end else begin
                  oe_w++;
                  chk(mem_address == oe_addr, "addr_stable", mem_address, oe_addr);
               end
            end else if (oe_prev) begin
               chk(oe_w == 2, "oe_width", oe_w, 2);
            end
            oe_prev = (mem_oe === 1'b1);
         end
      end
   end

   // ---------------- done monitor ----------------
   initial begin
      int e;
      int expc;
      forever begin
         @(negedge clock);
         if (!reset && done === 1'b1) begin
            if (done_q.size() == 0) chk(1'b0, "unexpected_done", 1, 0);
            else begin
               e    = done_q.pop_front();
               expc = (e < 0) ? last_stop + 2 : e;
               chk(cyc == expc, "done_timing", cyc, expc);
               chk(busy == 1'b0, "busy_at_done", busy, 0);
            end
         end
         if (watch_zero && mem_address == '0) saw_zero = 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [31:0] f, input logic [31:0] l);
      longint unsigned a;
      first_addr = f;
      last_addr  = l;
      start      = 1'b1;
      if (l < f) begin
         done_q.push_back(cyc + 1);
      end else begin
         for (a = {32'b0, f}; a <= {32'b0, l}; a++) begin
            addr_q.push_back(a[31:0]);
            frame_q.push_back('{word: mem_word(a[31:0]), first: (a == {32'b0, f}), acc: cyc});
         end
         done_q.push_back(-1);
      end
      @(negedge clock);
      start      = 1'b0;
      first_addr = $urandom;
      last_addr  = $urandom;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((frame_q.size() != 0 || addr_q.size() != 0 || done_q.size() != 0) && n < 3000) begin
         @(negedge clock);
         n++;
      end
      chk(n < 3000, "idle_timeout", n, 3000);
      @(negedge clock);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk(tx == 1'b1,        {tag, "_tx"},     tx, 1);
      chk(busy == 1'b0,      {tag, "_busy"},   busy, 0);
      chk(mem_oe == 1'b0,    {tag, "_mem_oe"}, mem_oe, 0);
   endtask

   initial begin
      int          n;
      int          kind;
      int          len;
      logic [31:0] f;
      logic [31:0] l;

      reset      = 1'b1;
      start      = 1'b0;
      first_addr = '0;
      last_addr  = '0;
      use_tbl    = 1'b1;
      seed       = '0;
      for (int i = 0; i < 16; i++) tbl[i] = 32'h0;

      // Reset state
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_idle_outputs("reset");
      chk(done == 1'b0,          "reset_done", done, 0);
      chk(mem_address == 32'h0,  "reset_addr", mem_address, 0);

      // Single word with a known bit pattern
      tbl[5] = 32'hA5A50F0F;
      issue(32'd5, 32'd5);
      wait_idle();
      check_idle_outputs("after_single");

      // Three-word dump in address order
      tbl[2] = 32'h1;
      tbl[3] = 32'h2;
      tbl[4] = 32'h3;
      issue(32'd2, 32'd4);
      wait_idle();

      // Rejected range
      issue(32'd9, 32'd3);
      wait_idle();
      check_idle_outputs("after_reject");

      // Start presented during the done cycle must be ignored
      issue(32'd2, 32'd2);
      n = 0;
      while (done !== 1'b1 && n < 500) begin
         @(negedge clock);
         n++;
      end
      chk(n < 500, "done_wait", n, 500);
      start      = 1'b1;
      first_addr = 32'd4;
      last_addr  = 32'd4;
      @(negedge clock);
      start = 1'b0;
      wait_idle();
      issue(32'd3, 32'd3);
      wait_idle();

      // Start mid-frame ignored, then reset mid-DATA of the second frame
      use_tbl = 1'b0;
      seed    = $urandom;
      issue(32'd100, 32'd101);
      repeat (40) @(negedge clock);
      start      = 1'b1;
      first_addr = 32'd0;
      last_addr  = 32'd5;
      @(negedge clock);
      start = 1'b0;
      repeat (160) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_idle_outputs("midreset");
      frame_q.delete();
      addr_q.delete();
      done_q.delete();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // All-ones address must not wrap
      watch_zero = 1'b1;
      issue(32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_idle();
      repeat (5) @(negedge clock);
      watch_zero = 1'b0;
      chk(!saw_zero, "addr_wrap", saw_zero, 0);

      // Randomized dumps
      for (int t = 0; t < 8; t++) begin
         seed = $urandom;
         kind = $urandom_range(0, 3);
         if (kind == 0) begin
            f = $urandom | 32'h1;
            l = $urandom % f;
         end else begin
            len = $urandom_range(1, 3);
            f   = $urandom_range(0, 32'h7FFFFFFF);
            l   = f + 32'(len - 1);
         end
         issue(f, l);
         wait_idle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
